sensor_readout_packer: RTL and testbench
========================================

Name: sensor_readout_packer

Overview:
- Receive path matching the pattern stream to the sensors.
- Collects the 16-bit readout stream coming back from the sensor and packs it into 256-bit words for the host-side readout FIFO.
- Frame length in 16-bit words is set by Num_Words; a partial final word is zero-padded.
- The sensor stream cannot be stalled, so a write while the FIFO is almost full is dropped and flagged.

Parameters:
DIN_W, 16, width of one sensor readout word
DOUT_W, 256, width of a packed FIFO word
LANES, 16, DOUT_W/DIN_W, readout words per packed word

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-low reset
Num_Words  in  32  16-bit words per frame; sampled on the accepted frame_start
frame_start  in  1  one-cycle pulse that starts a frame
din  in  16  sensor readout data
din_valid  in  1  din qualifier, one word per high cycle
fifo_din  out  256  packed word to the readout FIFO
fifo_wr_en  out  1  write strobe to the readout FIFO
fifo_almost_full  in  1  readout FIFO almost-full flag
busy  out  1  high while a frame is in progress (PACK or DONE state)
frame_done  out  1  one-cycle pulse at the end of a frame
overflow  out  1  sticky flag: at least one packed word was dropped
word_cnt  out  32  16-bit words accepted in the current frame
wr_cnt  out  32  packed words issued in the current frame, including dropped words

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - fifo_din, fifo_wr_en, frame_done, overflow, busy, word_cnt, wr_cnt, the lane index and the pack register all go to 0.
  - Reset mid-frame discards the partial word and issues no write.
- States: IDLE, PACK, DONE.
- IDLE:
  - din_valid is ignored.
  - frame_start with Num_Words != 0: latch Num_Words, clear word_cnt, wr_cnt, lane index and pack register, then go to PACK.
  - frame_start with Num_Words == 0: ignored, stay in IDLE.
- PACK:
  - On each din_valid, din goes into lane[idx] (bits idx*16+15 : idx*16). Lane 0 is the first word; the LSB-first order matches the transmit direction.
  - Each accepted din_valid increments idx and word_cnt.
  - frame_start is ignored while in PACK.
- Emit rule: a packed word is emitted when the 16th lane fills (idx=15), or when the frame's last word arrives (word_cnt+1 == latched Num_Words), whichever comes first.
  - fifo_din is registered and presented in the cycle after that din_valid (latency 1).
  - Unfilled lanes are 0.
  - idx wraps to 0 and the pack register clears.
- Write/drop decision, made in the emit cycle:
  - fifo_almost_full=0: fifo_wr_en=1 for exactly that cycle.
  - fifo_almost_full=1: fifo_wr_en stays 0, the word is dropped and overflow is set.
  - wr_cnt increments in either case.
- Frame end: after the last word, PACK goes to DONE. The write (or drop) happens in the DONE cycle.
- DONE lasts one cycle, then frame_done is a one-cycle pulse on the following cycle and the state returns to IDLE.
  - Timing: last din_valid at cycle t, fifo_wr_en at t+1, frame_done at t+2.
  - busy is 1 in PACK and DONE, and falls in the same cycle frame_done rises.
- din_valid while in DONE is ignored; it does not count and is not stored.
- overflow clears only on reset; it survives frame_start.
- Counter widths:
  - word_cnt and wr_cnt are 32-bit.
  - wr_cnt at frame end is ceil(Num_Words/16).
  - Num_Words=2^32-1 is legal; no counter overflows within a frame.
- fifo_din holds its last value when fifo_wr_en=0.

Test Plan:
1. Full words: rst low for 4 cycles, Num_Words=32, frame_start, din=0x0000..0x001F on consecutive cycles.
   - Expect 2 writes: word0 = {0x000F,...,0x0001,0x0000}, word1 = {0x001F,...,0x0010}.
   - fifo_wr_en 1 cycle after the 16th and 32nd valids; frame_done 2 cycles after the last valid; wr_cnt=2; overflow=0.
2. Partial last word: Num_Words=20, din=0xA000+i.
   - Expect 2 writes; second word lanes 0..3 = 0xA010..0xA013, lanes 4..15 = 0.
   - word_cnt=20, wr_cnt=2.
3. Gappy valids: Num_Words=16, din_valid high every 3rd cycle.
   - Expect a single write carrying all 16 values in order; no writes before then.
4. Drop on almost full: Num_Words=48, fifo_almost_full=1 during the second emit cycle only.
   - Expect writes for words 0 and 2 only, overflow=1 staying high through a following frame, wr_cnt=3.
5. Ignored starts: frame_start with Num_Words=0 leaves busy=0 and no writes.
   - frame_start mid-frame (Num_Words=16, pulse after 5 words) does not restart; one write of 16 words.
6. Reset mid-frame: rst=0 after 10 of 16 words.
   - Expect no fifo_wr_en, all outputs 0, state IDLE.
   - A following 16-word frame packs correctly starting at lane 0.

Source files
------------

// File: rtl/sensor_readout_packer.sv
// sensor_readout_packer: packs the 16-bit sensor readout stream into 256-bit words for the readout FIFO.
// Writes are never stalled; a word emitted while the FIFO is almost full is dropped and overflow is flagged.
module sensor_readout_packer #(
   parameter int DIN_W  = 16,
   parameter int DOUT_W = 256,
   parameter int LANES  = DOUT_W / DIN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       Num_Words,
   input  logic              frame_start,
   input  logic [DIN_W-1:0]  din,
   input  logic              din_valid,
   output logic [DOUT_W-1:0] fifo_din,
   output logic              fifo_wr_en,
   input  logic              fifo_almost_full,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow,
   output logic [31:0]       word_cnt,
   output logic [31:0]       wr_cnt
);
   localparam int IW = $clog2(LANES);
   typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;
   state_t            state_q, state_d;
   logic [31:0]       num_q, num_d, word_cnt_q, word_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DOUT_W-1:0] pack_q, pack_d, fifo_din_q, fifo_din_d, merged;
   logic              fifo_wr_en_q, fifo_wr_en_d, frame_done_q, frame_done_d;
   logic              overflow_q, overflow_d, busy_q, busy_d;
   logic              accept, last, emit, start;
   always_comb begin
      merged = pack_q;
      merged[idx_q*DIN_W +: DIN_W] = din;
      accept = (state_q == PACK) && din_valid;
      last = (word_cnt_q + 32'd1) == num_q;
      emit = accept && (idx_q == IW'(LANES - 1) || last);
      start = (state_q == IDLE) && frame_start && (Num_Words != 32'd0);
      // the drop decision is taken on the emitting din_valid, so the write strobe lands one cycle later
      fifo_wr_en_d = emit && !fifo_almost_full;
      overflow_d = overflow_q || (emit && fifo_almost_full);
      fifo_din_d = fifo_wr_en_d ? merged : fifo_din_q;
      num_d = start ? Num_Words : num_q;
      word_cnt_d = start ? 32'd0 : accept ? word_cnt_q + 32'd1 : word_cnt_q;
      wr_cnt_d = start ? 32'd0 : emit ? wr_cnt_q + 32'd1 : wr_cnt_q;
      idx_d = (start || emit) ? '0 : accept ? idx_q + 1'b1 : idx_q;
      pack_d = (start || emit) ? '0 : accept ? merged : pack_q;
      frame_done_d = state_q == DONE;
      state_d = start ? PACK : (accept && last) ? DONE : (state_q == DONE) ? IDLE : state_q;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         num_q        <= '0;
         word_cnt_q   <= '0;
         wr_cnt_q     <= '0;
         idx_q        <= '0;
         pack_q       <= '0;
         fifo_din_q   <= '0;
         fifo_wr_en_q <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         num_q        <= num_d;
         word_cnt_q   <= word_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         idx_q        <= idx_d;
         pack_q       <= pack_d;
         fifo_din_q   <= fifo_din_d;
         fifo_wr_en_q <= fifo_wr_en_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         busy_q       <= busy_d;
      end
   end
   assign fifo_din   = fifo_din_q;
   assign fifo_wr_en = fifo_wr_en_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign busy       = busy_q;
   assign word_cnt   = word_cnt_q;
   assign wr_cnt     = wr_cnt_q;
endmodule

// File: tb/tb_sensor_readout_packer.sv
// tb_sensor_readout_packer: directed frames with a write/frame_done scoreboard checked by a monitor.
module tb_sensor_readout_packer;
   logic         clk = 1'b0, rst = 1'b0;
   logic [31:0]  num_words = '0;
   logic         frame_start = 1'b0, din_valid = 1'b0, fifo_almost_full = 1'b0;
   logic [15:0]  din = '0;
   logic [255:0] fifo_din;
   logic         fifo_wr_en, busy, frame_done, overflow;
   logic [31:0]  word_cnt, wr_cnt;
   int errors = 0, checks = 0, cyc = 0;
   typedef struct {logic [255:0] data; int at;} wr_t;
   wr_t wq[$];
   int  dq[$];
   wr_t exp_wr;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   sensor_readout_packer dut (
      .clk(clk), .rst(rst), .Num_Words(num_words), .frame_start(frame_start),
      .din(din), .din_valid(din_valid), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
      .fifo_almost_full(fifo_almost_full), .busy(busy), .frame_done(frame_done),
      .overflow(overflow), .word_cnt(word_cnt), .wr_cnt(wr_cnt)
   );
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (fifo_wr_en) begin
         if (wq.size() == 0) chk("unexpected_write", fifo_wr_en, 0);
         else begin
            exp_wr = wq.pop_front();
            chk("wr_data", fifo_din, exp_wr.data);
            chk("wr_cycle", cyc, exp_wr.at);
         end
      end
      if (frame_done) begin
         if (dq.size() == 0) chk("unexpected_done", frame_done, 0);
         else chk("done_cycle", cyc, dq.pop_front());
      end
   end
   task automatic run_frame(input int n, input logic [15:0] base, input int gap,
                            input int drop_emit, input int restart_at, input logic exp_ovf);
      logic [255:0] acc;
      int lane, emits;
      logic e;
      acc = '0; lane = 0; emits = 0;
      @(posedge clk); #1 num_words = n; frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == 0) chk("busy_in_frame", busy, 1);
         din = base + 16'(i);
         din_valid = 1'b1;
         acc[lane*16 +: 16] = din;
         e = (lane == 15) || (i == n - 1);
         fifo_almost_full = e && (emits == drop_emit);
         frame_start = (i == restart_at);
         if (i == restart_at) num_words = 4;
         if (e) begin
            if (emits != drop_emit) wq.push_back(wr_t'{acc, cyc + 1});
            emits++; acc = '0; lane = 0;
         end else lane++;
         if (i == n - 1) dq.push_back(cyc + 2);
         @(posedge clk); #1 din_valid = 1'b0; fifo_almost_full = 1'b0; frame_start = 1'b0;
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
         end
      end
      repeat (3) @(negedge clk);
      chk("busy_after", busy, 0);
      chk("word_cnt", word_cnt, n);
      chk("wr_cnt", wr_cnt, (n + 15) / 16);
      chk("overflow", overflow, exp_ovf);
   endtask
   initial begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_fifo_din", fifo_din, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_wr_cnt", wr_cnt, 0);
      @(posedge clk); #1 rst = 1'b1;
      run_frame(32, 16'h0000, 0, -1, -1, 1'b0);
      chk("t1_hold", fifo_din, 256'h001f001e001d001c001b001a0019001800170016001500140013001200110010);
      run_frame(20, 16'hA000, 0, -1, -1, 1'b0);
      chk("t2_partial", fifo_din, 256'hA013A012A011A010);
      run_frame(16, 16'h3000, 2, -1, -1, 1'b0);
      run_frame(48, 16'h4000, 0, 1, -1, 1'b1);
      @(posedge clk); #1 num_words = 0; frame_start = 1'b1; din = 16'hFFFF; din_valid = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0; din_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_zero_busy", busy, 0);
      chk("t5_zero_word_cnt", word_cnt, 48);
      run_frame(16, 16'h5000, 0, -1, 5, 1'b1);
      @(posedge clk); #1 num_words = 16; frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         din = 16'hB000 + 16'(i); din_valid = 1'b1;
         @(posedge clk); #1;
      end
      din_valid = 1'b0; rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t6_fifo_din", fifo_din, 0);
      chk("t6_wr_en", fifo_wr_en, 0);
      chk("t6_busy", busy, 0);
      chk("t6_done", frame_done, 0);
      chk("t6_overflow", overflow, 0);
      chk("t6_word_cnt", word_cnt, 0);
      chk("t6_wr_cnt", wr_cnt, 0);
      @(posedge clk); #1 rst = 1'b1;
      run_frame(16, 16'h6000, 0, -1, -1, 1'b0);
      repeat (5) @(negedge clk);
      chk("writes_pending", wq.size(), 0);
      chk("dones_pending", dq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
